// File: rtl/conv_pool_relu_if.sv
// Stream bundle for conv_pool_relu.
// The slave side is the pooling stage; the master side is whoever feeds
// column beats in and drains pooled words out.
interface conv_pool_relu_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/conv_pool_relu.sv
// ReLU + 2x2/stride-2 max-pool + right-shift requantisation + 8-bit saturation
// over 4-lane signed column beats from the convolution core.
//
// state | meaning
// EMPTY | no column held; next beat becomes column A (or a zero-partner tail)
// HELD  | column A registered; next beat is B and completes a pooled word
module conv_pool_relu #(
  parameter int COLS  = 8,
  parameter int SHIFT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_clr,
  conv_pool_relu_if.slave   io,
  output logic              frame_done,
  output logic [15:0]       sat_cnt
);

  typedef enum logic {EMPTY = 1'b0, HELD = 1'b1} state_t;

  localparam logic [3:0] LAST_COL = 4'(COLS - 1);

  state_t      state_q, state_d;
  logic [3:0]  col_cnt_q, col_cnt_d;
  logic [63:0] a_q, a_d;
  logic        out_valid_q, out_valid_d;
  logic [15:0] out_data_q, out_data_d;
  logic        out_last_q, out_last_d;
  logic        frame_done_q, frame_done_d;
  logic [15:0] sat_cnt_q, sat_cnt_d;

  logic        last_col;
  logic        produces;
  logic        out_fire;
  logic        accept;
  logic [63:0] partner;
  logic [8:0]  byte0;
  logic [8:0]  byte1;
  logic [16:0] sat_sum;

  function automatic logic [14:0] relu(input logic [15:0] x);
    return x[15] ? 15'd0 : x[14:0];
  endfunction

  // Result is {saturated, byte}.
  function automatic logic [8:0] pool_byte(input logic [15:0] a0, input logic [15:0] a1,
                                           input logic [15:0] b0, input logic [15:0] b1);
    logic [14:0] m;
    logic [14:0] q;
    m = relu(a0);
    if (relu(a1) > m) m = relu(a1);
    if (relu(b0) > m) m = relu(b0);
    if (relu(b1) > m) m = relu(b1);
    q = m >> SHIFT;
    return (q > 15'd255) ? {1'b1, 8'hFF} : {1'b0, q[7:0]};
  endfunction

  // Handshake qualification and pooled-word datapath.
  always_comb begin
    last_col    = (col_cnt_q == LAST_COL);
    produces    = (state_q == HELD) | last_col;
    out_fire    = out_valid_q & io.out_ready;
    // A beat that only gets stored never waits on the output register.
    io.in_ready = !frame_clr & (!produces | !out_valid_q | io.out_ready);
    accept      = io.in_valid & io.in_ready;
    // An odd-COLS tail pools against an all-zero partner.
    partner     = (state_q == HELD) ? a_q : 64'd0;
    byte0       = pool_byte(partner[15:0], partner[31:16], io.in_data[15:0], io.in_data[31:16]);
    byte1       = pool_byte(partner[47:32], partner[63:48], io.in_data[47:32], io.in_data[63:48]);
    sat_sum     = {1'b0, sat_cnt_q} + 17'(byte0[8]) + 17'(byte1[8]);
  end

  // Next-state: column pairing, output register load/drain, counters.
  always_comb begin
    state_d      = state_q;
    col_cnt_d    = col_cnt_q;
    a_d          = a_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    frame_done_d = 1'b0;
    sat_cnt_d    = sat_cnt_q;

    if (frame_clr) begin
      state_d     = EMPTY;
      col_cnt_d   = 4'd0;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      sat_cnt_d   = 16'd0;
    end else begin
      if (out_fire) begin
        out_valid_d  = 1'b0;
        out_last_d   = 1'b0;
        frame_done_d = out_last_q;
      end
      if (accept) begin
        if (produces) begin
          out_valid_d = 1'b1;
          out_data_d  = {byte1[7:0], byte0[7:0]};
          out_last_d  = last_col;
          sat_cnt_d   = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
          col_cnt_d   = last_col ? 4'd0 : col_cnt_q + 4'd1;
          state_d     = EMPTY;
        end else begin
          a_d       = io.in_data;
          col_cnt_d = col_cnt_q + 4'd1;
          state_d   = HELD;
        end
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= EMPTY;
      col_cnt_q    <= 4'd0;
      a_q          <= 64'd0;
      out_valid_q  <= 1'b0;
      out_data_q   <= 16'd0;
      out_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
      sat_cnt_q    <= 16'd0;
    end else begin
      state_q      <= state_d;
      col_cnt_q    <= col_cnt_d;
      a_q          <= a_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      frame_done_q <= frame_done_d;
      sat_cnt_q    <= sat_cnt_d;
    end
  end

  assign io.out_valid = out_valid_q;
  assign io.out_data  = out_data_q;
  assign io.out_last  = out_last_q;
  assign frame_done   = frame_done_q;
  assign sat_cnt      = sat_cnt_q;

endmodule

// File: tb/tb_conv_pool_relu.sv
// Directed bench for conv_pool_relu: a COLS=8 instance for the main table,
// throughput, backpressure and abort cases, and a COLS=5 instance for the odd tail.
module tb_conv_pool_relu;

  logic        clk;
  logic        rst;
  logic        frame_clr;
  logic        frame_done8, frame_done5;
  logic [15:0] sat8, sat5;

  conv_pool_relu_if if8 ();
  conv_pool_relu_if if5 ();

  conv_pool_relu #(.COLS(8), .SHIFT(4)) dut8 (
    .clk(clk), .rst(rst), .frame_clr(frame_clr), .io(if8),
    .frame_done(frame_done8), .sat_cnt(sat8)
  );

  conv_pool_relu #(.COLS(5), .SHIFT(4)) dut5 (
    .clk(clk), .rst(rst), .frame_clr(frame_clr), .io(if5),
    .frame_done(frame_done5), .sat_cnt(sat5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [15:0] exp_data;
    int          nsat;
  } vec_t;

  vec_t tbl[8];

  function automatic logic [63:0] pk(input int l0, input int l1, input int l2, input int l3);
    return {16'(l3), 16'(l2), 16'(l1), 16'(l0)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic beat8(input logic [63:0] d);
    int n;
    n = 0;
    if8.in_valid = 1'b1;
    if8.in_data  = d;
    @(negedge clk);
    while (!if8.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!if8.in_ready) chk("beat8_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    if8.in_valid = 1'b0;
  endtask

  task automatic beat5(input logic [63:0] d);
    int n;
    n = 0;
    if5.in_valid = 1'b1;
    if5.in_data  = d;
    @(negedge clk);
    while (!if5.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!if5.in_ready) chk("beat5_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    if5.in_valid = 1'b0;
  endtask

  task automatic clr();
    frame_clr = 1'b1;
    @(posedge clk);
    #1;
    frame_clr = 1'b0;
  endtask

  // Park HELD with an undelivered word, then abort via frame_clr or rst.
  task automatic abort_case(input bit use_rst);
    clr();
    if8.out_ready = 1'b0;
    beat8(pk(0, 0, 0, 0));
    beat8(pk(5000, 0, 0, 0));
    chk("abort_pending_valid", 32'(if8.out_valid), 32'd1);
    chk("abort_pending_sat", 32'(sat8), 32'd1);
    beat8(pk(1600, 0, 0, 0));
    @(negedge clk);
    if (use_rst) rst = 1'b1;
    else         frame_clr = 1'b1;
    #1;
    if (!use_rst) chk("abort_clr_in_ready", 32'(if8.in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    frame_clr = 1'b0;
    chk("abort_out_valid", 32'(if8.out_valid), 32'd0);
    chk("abort_sat_cnt", 32'(sat8), 32'd0);
    if8.out_ready = 1'b1;
    beat8(pk(0, 0, 320, 0));
    chk("abort_col0_no_word", 32'(if8.out_valid), 32'd0);
    beat8(pk(48, 0, 0, 0));
    chk("abort_col1_valid", 32'(if8.out_valid), 32'd1);
    chk("abort_col1_data", 32'(if8.out_data), 32'h1403);
    chk("abort_col1_last", 32'(if8.out_last), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_sat;
    int sent, words, dones, stalls, lastpos;
    bit accepted;

    tbl[0] = '{pk(100, -50, 300, 4095), pk(200, 40, -1, 5000), 16'hFF0C, 1};
    tbl[1] = '{pk(-32768, -32768, -32768, -32768), pk(-32768, -32768, -32768, -32768), 16'h0000, 0};
    tbl[2] = '{pk(16, 15, 0, 0), pk(0, 0, 0, 0), 16'h0001, 0};
    tbl[3] = '{pk(4095, 4080, 4096, 0), pk(0, 0, 0, 0), 16'hFFFF, 1};
    tbl[4] = '{pk(32767, -1, -32768, 255), pk(1, 2, 3, 4), 16'h0FFF, 1};
    tbl[5] = '{pk(0, 0, 0, 0), pk(0, 0, 0, 0), 16'h0000, 0};
    tbl[6] = '{pk(-5, -6, -7, -8), pk(4080, 17, 4111, -1), 16'hFFFF, 1};
    tbl[7] = '{pk(80, 160, 1, 2), pk(40, 20, 3, 4), 16'h000A, 0};

    rst           = 1'b1;
    frame_clr     = 1'b0;
    if8.in_valid  = 1'b0;
    if8.in_data   = '0;
    if8.out_ready = 1'b1;
    if5.in_valid  = 1'b0;
    if5.in_data   = '0;
    if5.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    @(negedge clk);
    chk("rst_in_ready", 32'(if8.in_ready), 32'd1);
    chk("rst_out_valid", 32'(if8.out_valid), 32'd0);
    chk("rst_out_data", 32'(if8.out_data), 32'd0);
    chk("rst_out_last", 32'(if8.out_last), 32'd0);
    chk("rst_frame_done", 32'(frame_done8), 32'd0);
    chk("rst_sat_cnt", 32'(sat8), 32'd0);
    @(posedge clk);
    #1;

    // Table: eight consecutive pairs = two COLS=8 frames with no gap.
    exp_sat = 0;
    for (int i = 0; i < 8; i++) begin
      beat8(tbl[i].a);
      chk($sformatf("tbl%0d_a_no_word", i), 32'(if8.out_valid), 32'd0);
      beat8(tbl[i].b);
      exp_sat += tbl[i].nsat;
      chk($sformatf("tbl%0d_valid", i), 32'(if8.out_valid), 32'd1);
      chk($sformatf("tbl%0d_data", i), 32'(if8.out_data), 32'(tbl[i].exp_data));
      chk($sformatf("tbl%0d_last", i), 32'(if8.out_last), 32'((i % 4) == 3));
      chk($sformatf("tbl%0d_sat", i), 32'(sat8), 32'(exp_sat));
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_frame_done", i), 32'(frame_done8), 32'((i % 4) == 3));
      chk($sformatf("tbl%0d_drained", i), 32'(if8.out_valid), 32'd0);
    end

    // Full-throughput frame: 8 beats back to back, out_ready held high.
    clr();
    sent = 0; words = 0; dones = 0; stalls = 0; lastpos = -1;
    if8.in_valid = 1'b1;
    if8.in_data  = pk(0, 0, 0, 0);
    for (int cyc = 0; cyc < 14; cyc++) begin
      @(negedge clk);
      if (if8.out_valid && if8.out_ready) begin
        chk($sformatf("tput_word%0d_data", words), 32'(if8.out_data), 32'(2 * words + 1));
        if (if8.out_last) lastpos = words;
        words++;
      end
      if (frame_done8) dones++;
      if (if8.in_valid && !if8.in_ready) stalls++;
      accepted = if8.in_valid && if8.in_ready;
      @(posedge clk);
      #1;
      if (accepted) begin
        sent++;
        if (sent < 8) if8.in_data = pk(sent * 16, 0, 0, 0);
        else          if8.in_valid = 1'b0;
      end
    end
    chk("tput_words", 32'(words), 32'd4);
    chk("tput_last_pos", 32'(lastpos), 32'd3);
    chk("tput_frame_done", 32'(dones), 32'd1);
    chk("tput_stalls", 32'(stalls), 32'd0);
    chk("tput_beats", 32'(sent), 32'd8);

    // Backpressure: first word held, second pair's completing beat must stall.
    clr();
    if8.out_ready = 1'b0;
    beat8(pk(160, 0, 48, 0));
    beat8(pk(0, 0, 0, 0));
    beat8(pk(0, 800, 0, 0));
    if8.in_valid = 1'b1;
    if8.in_data  = pk(0, 0, 0, 1600);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("bp%0d_in_ready", k), 32'(if8.in_ready), 32'd0);
      chk($sformatf("bp%0d_valid", k), 32'(if8.out_valid), 32'd1);
      chk($sformatf("bp%0d_data", k), 32'(if8.out_data), 32'h030A);
    end
    if8.out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 32'(if8.in_ready), 32'd1);
    @(posedge clk);
    #1;
    if8.in_valid = 1'b0;
    chk("bp_w2_valid", 32'(if8.out_valid), 32'd1);
    chk("bp_w2_data", 32'(if8.out_data), 32'h6432);
    chk("bp_w2_last", 32'(if8.out_last), 32'd0);
    @(posedge clk);
    #1;
    chk("bp_drained", 32'(if8.out_valid), 32'd0);

    abort_case(1'b0);
    abort_case(1'b1);

    // Odd tail on the COLS=5 instance.
    clr();
    beat5(pk(0, 0, 0, 0));
    beat5(pk(0, 0, 0, 0));
    chk("tail_pair0_last", 32'(if5.out_last), 32'd0);
    beat5(pk(0, 0, 0, 0));
    beat5(pk(0, 0, 0, 0));
    chk("tail_pair1_last", 32'(if5.out_last), 32'd0);
    beat5(pk(64, 0, 32, 16));
    chk("tail_valid", 32'(if5.out_valid), 32'd1);
    chk("tail_data", 32'(if5.out_data), 32'h0204);
    chk("tail_last", 32'(if5.out_last), 32'd1);
    @(posedge clk);
    #1;
    chk("tail_frame_done", 32'(frame_done5), 32'd1);
    chk("tail_drained", 32'(if5.out_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("tail_frame_done_one_cycle", 32'(frame_done5), 32'd0);
    beat5(pk(32, 0, 0, 0));
    chk("tail_wrap_no_word", 32'(if5.out_valid), 32'd0);
    beat5(pk(0, 0, 0, 0));
    chk("tail_wrap_data", 32'(if5.out_data), 32'h0002);
    chk("tail_wrap_last", 32'(if5.out_last), 32'd0);
    chk("tail_sat", 32'(sat5), 32'd0);
    @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
